// File: rtl/stereo_codec_conditioner.sv
// Stereo sample FIFO between the conditioner and the codec: one {l,r} pair leaves per codec frame, re-primes after underrun.
// Outputs registered (1-cycle latency) except sample_req; a sample arriving while full with no pop is dropped (overrun pulse).
module stereo_codec_conditioner #(
  parameter int DEPTH       = 4,
  parameter int PRIME_LEVEL = DEPTH / 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            sample_l_in,
  input  logic [15:0]            sample_r_in,
  input  logic                   new_sample_in,
  input  logic                   new_frame,
  output logic                   sample_req,
  output logic [15:0]            codec_l,
  output logic [15:0]            codec_r,
  output logic [$clog2(DEPTH):0] count,
  output logic                   running,
  output logic                   overrun,
  output logic                   underrun
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_PRIME = (AW+1)'(PRIME_LEVEL);

  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;
  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  state_t        r_state;
  state_t        w_state_next;
  pair_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_codec_l;
  logic [15:0]   r_codec_r;
  logic          r_overrun;
  logic          r_underrun;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_starve;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_pop    = new_frame && running && !w_empty;
  assign w_starve = new_frame && running && w_empty;
  // A full FIFO still takes a sample when the same cycle frees a slot.
  assign w_push   = new_sample_in && (!w_full || w_pop);
  assign w_drop   = new_sample_in && !w_push;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PRIME: if (r_count >= CNT_PRIME) w_state_next = ST_RUN;
      ST_RUN:   if (w_starve)             w_state_next = ST_PRIME;
      default:                            w_state_next = ST_PRIME;
    endcase
  end

  always_comb begin
    running    = (r_state == ST_RUN);
    sample_req = (r_count < CNT_FULL);
    count      = r_count;
    codec_l    = r_codec_l;
    codec_r    = r_codec_r;
    overrun    = r_overrun;
    underrun   = r_underrun;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_codec_l  <= '0;
      r_codec_r  <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_codec_l <= r_mem[r_rd_ptr].l;
        r_codec_r <= r_mem[r_rd_ptr].r;
      end
      r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_overrun  <= w_drop;
      r_underrun <= w_starve;
    end
  end

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_mem[r_wr_ptr] <= '{l: sample_l_in, r: sample_r_in};
    end
  end
endmodule

// File: tb/tb_stereo_codec_conditioner.sv
// Bench for stereo_codec_conditioner: directed vector table plus randomized traffic against a queue-based model.
module tb_stereo_codec_conditioner;
  localparam int DEPTH       = 4;
  localparam int PRIME_LEVEL = 2;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   sample_l_in;
  logic [15:0]   sample_r_in;
  logic          new_sample_in;
  logic          new_frame;
  logic          sample_req;
  logic [15:0]   codec_l;
  logic [15:0]   codec_r;
  logic [CW-1:0] count;
  logic          running;
  logic          overrun;
  logic          underrun;

  always #5 clk = ~clk;

  stereo_codec_conditioner #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_l_in(sample_l_in), .sample_r_in(sample_r_in),
    .new_sample_in(new_sample_in), .new_frame(new_frame),
    .sample_req(sample_req), .codec_l(codec_l), .codec_r(codec_r),
    .count(count), .running(running), .overrun(overrun), .underrun(underrun)
  );

  typedef struct {
    logic        rn, ns, nf;
    logic [15:0] l, r;
    logic [15:0] cl, cr;
    int          cnt;
    logic        run, ov, un, req;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] m_q[$];
  logic        m_run;
  logic [15:0] m_cl, m_cr;
  logic        m_ov, m_un;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rn, ns, nf, input logic [15:0] l, r, cl, cr,
                     input int cnt, input logic run, ov, un, req);
    vec_t v;
    v.rn = rn; v.ns = ns; v.nf = nf; v.l = l; v.r = r;
    v.cl = cl; v.cr = cr; v.cnt = cnt; v.run = run; v.ov = ov; v.un = un; v.req = req;
    tbl.push_back(v);
  endtask

  // Reference: FIFO as a queue, state as a single "running" flag, rules applied to pre-edge state.
  task automatic model_update(input logic rn, ns, nf, input logic [15:0] l, r);
    int          sz;
    bit          pop, starve, accept;
    logic [31:0] head;
    sz = m_q.size();
    if (!rn) begin
      m_q.delete();
      m_run = 1'b0; m_cl = '0; m_cr = '0; m_ov = 1'b0; m_un = 1'b0;
      return;
    end
    pop    = nf && m_run && (sz > 0);
    starve = nf && m_run && (sz == 0);
    accept = ns && ((sz < DEPTH) || pop);
    m_ov   = ns && !accept;
    m_un   = starve;
    if (pop) begin
      head = m_q.pop_front();
      m_cl = head[31:16];
      m_cr = head[15:0];
    end
    if (accept) m_q.push_back({l, r});
    if (m_run) m_run = !starve;
    else       m_run = (sz >= PRIME_LEVEL);
  endtask

  task automatic step(input logic rn, ns, nf, input logic [15:0] l, r);
    reset_n = rn; new_sample_in = ns; new_frame = nf; sample_l_in = l; sample_r_in = r;
    @(posedge clk);
    model_update(rn, ns, nf, l, r);
    #1;
    cyc++;
    chk("mdl_codec_l", codec_l, m_cl);
    chk("mdl_codec_r", codec_r, m_cr);
    chk("mdl_count", count, m_q.size());
    chk("mdl_running", running, m_run);
    chk("mdl_overrun", overrun, m_ov);
    chk("mdl_underrun", underrun, m_un);
    chk("mdl_sample_req", sample_req, m_q.size() < DEPTH);
  endtask

  initial begin
    vec_t v;
    logic prev_nf;
    int   pct;
    logic rn, ns, nf;
    reset_n = 1'b0; new_sample_in = 1'b0; new_frame = 1'b0; sample_l_in = '0; sample_r_in = '0;

    // rn ns nf  l  r | codec_l codec_r count running overrun underrun sample_req
    add(0,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0,0,0,0,1);
    add(0,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0,0,0,0,1);
    add(1,1,0,16'h0064,16'hFF9C, 16'h0000,16'h0000,1,0,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h0000,16'h0000,1,0,0,0,1);
    add(1,1,0,16'h00C8,16'hFF38, 16'h0000,16'h0000,2,0,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,2,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h0064,16'hFF9C,1,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0064,16'hFF9C,1,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h00C8,16'hFF38,0,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h00C8,16'hFF38,0,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h00C8,16'hFF38,0,0,0,1,1);
    add(1,0,0,16'h0000,16'h0000, 16'h00C8,16'hFF38,0,0,0,0,1);
    // re-prime, then drain (7,9) and starve on the next frame
    add(1,1,0,16'h0005,16'h0006, 16'h00C8,16'hFF38,1,0,0,0,1);
    add(1,1,0,16'h0007,16'h0009, 16'h00C8,16'hFF38,2,0,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h00C8,16'hFF38,2,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h0005,16'h0006,1,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0005,16'h0006,1,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h0007,16'h0009,0,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0007,16'h0009,0,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0007,16'h0009,0,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0007,16'h0009,0,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h0007,16'h0009,0,0,0,1,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0007,16'h0009,0,0,0,0,1);
    // overrun from reset: five back-to-back pushes
    add(0,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0,0,0,0,1);
    add(1,1,0,16'h1001,16'h2001, 16'h0000,16'h0000,1,0,0,0,1);
    add(1,1,0,16'h1002,16'h2002, 16'h0000,16'h0000,2,0,0,0,1);
    add(1,1,0,16'h1003,16'h2003, 16'h0000,16'h0000,3,1,0,0,1);
    add(1,1,0,16'h1004,16'h2004, 16'h0000,16'h0000,4,1,0,0,0);
    add(1,1,0,16'h1005,16'h2005, 16'h0000,16'h0000,4,1,1,0,0);
    add(1,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,4,1,0,0,0);
    // simultaneous pop and push at full
    add(1,1,1,16'h7FFF,16'h8000, 16'h1001,16'h2001,4,1,0,0,0);
    add(1,0,0,16'h0000,16'h0000, 16'h1001,16'h2001,4,1,0,0,0);
    add(1,0,1,16'h0000,16'h0000, 16'h1002,16'h2002,3,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h1002,16'h2002,3,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h1003,16'h2003,2,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h1003,16'h2003,2,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h1004,16'h2004,1,1,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h1004,16'h2004,1,1,0,0,1);
    add(1,0,1,16'h0000,16'h0000, 16'h7FFF,16'h8000,0,1,0,0,1);
    // reset mid-operation with a frame and a sample in flight
    add(1,1,0,16'hAAAA,16'h5555, 16'h7FFF,16'h8000,1,1,0,0,1);
    add(1,1,0,16'hAAAB,16'h5556, 16'h7FFF,16'h8000,2,1,0,0,1);
    add(1,1,0,16'hAAAC,16'h5557, 16'h7FFF,16'h8000,3,1,0,0,1);
    add(0,1,1,16'h1234,16'h5678, 16'h0000,16'h0000,0,0,0,0,1);
    add(1,0,0,16'h0000,16'h0000, 16'h0000,16'h0000,0,0,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.rn, v.ns, v.nf, v.l, v.r);
      chk($sformatf("vec%0d_codec_l", i), codec_l, v.cl);
      chk($sformatf("vec%0d_codec_r", i), codec_r, v.cr);
      chk($sformatf("vec%0d_count", i), count, v.cnt);
      chk($sformatf("vec%0d_running", i), running, v.run);
      chk($sformatf("vec%0d_overrun", i), overrun, v.ov);
      chk($sformatf("vec%0d_underrun", i), underrun, v.un);
      chk($sformatf("vec%0d_sample_req", i), sample_req, v.req);
    end

    // Randomized traffic; producer rate varies by phase to hit both overrun and underrun.
    prev_nf = 1'b0;
    for (int i = 0; i < 3200; i++) begin
      case ((i / 400) % 4)
        0:       pct = 85;
        1:       pct = 20;
        2:       pct = 50;
        default: pct = 100;
      endcase
      rn = ($urandom_range(0, 249) != 0);
      ns = ($urandom_range(0, 99) < pct);
      nf = prev_nf ? 1'b0 : ($urandom_range(0, 2) == 0);
      prev_nf = nf;
      step(rn, ns, nf, 16'($urandom), 16'($urandom));
    end

    // Reset held for two edges after random activity.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      chk("rst_codec_l", codec_l, 16'h0000);
      chk("rst_codec_r", codec_r, 16'h0000);
      chk("rst_count", count, 0);
      chk("rst_running", running, 1'b0);
      chk("rst_sample_req", sample_req, 1'b1);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
